pps_monitor: RTL and testbench
==============================

Name: pps_monitor

Overview:
- Conditions the raw GPS PPS input for the PS.
- Synchronises PPS into the bus_clk domain and produces a clean edge strobe, a GPIO-level copy and a stretched IRQ.
- Measures the period between PPS edges and keeps a lock/loss state machine; software reads it through ps_gpio_in and IRQ_F2P.
- Sits between the GPS_PPS pad and the PS GPIO/interrupt inputs. It replaces the ad-hoc 3-stage pps shift register in the top level.

Parameters:
- CLK_FREQ, 100000000, nominal bus_clk cycles per PPS period.
- TOLERANCE, 1000, allowed deviation in cycles (±) for a "good" period.
- LOCK_COUNT, 3, consecutive good periods required to assert locked (≥1).
- IRQ_STRETCH, 8, cycles pps_irq stays high after each PPS edge (≥1).
- CNT_W, 32, period counter width; must hold CLK_FREQ+TOLERANCE+1.

Ports:
- bus_clk  in  1  bus clock (100 MHz).
- bus_rst  in  1  asynchronous active-high reset.
- pps_in  in  1  raw PPS, asynchronous to bus_clk.
- pps_out  out  1  synchronised PPS level, for ps_gpio_in.
- pps_pulse  out  1  one-cycle strobe per PPS rising edge.
- pps_irq  out  1  stretched PPS interrupt.
- period  out  CNT_W  last measured period in cycles.
- period_valid  out  1  one-cycle strobe when period updates.
- locked  out  1  PPS is in-window and stable.
- loss  out  1  one-cycle strobe on lock loss or timeout.

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, counter 0, good_cnt 0, state SEARCH. Reset is asynchronous assert; deassertion is expected to be synchronised upstream by reset_sync.
- Sync: two flops (s0, s1) feed a third flop, d. pps_out = d. pps_pulse is registered as s1 & ~d.
- Latency: pps_pulse is high on the 3rd bus_clk edge after pps_in rises, provided setup is met. pps_out rises on the same edge.
- Elapsed counter: clears on every pps_pulse cycle, otherwise increments, saturating at all-ones.
- Measured period P = number of bus_clk cycles between consecutive pps_pulse assertions.
- Good window: CLK_FREQ-TOLERANCE ≤ P ≤ CLK_FREQ+TOLERANCE.
- State SEARCH: waits for pps_pulse, then goes to MEASURE. No period is reported for the first edge.
- State MEASURE, on pps_pulse:
  - period ← P and period_valid pulses.
  - If P is good: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1 on the same edge.
  - If P is bad: good_cnt ← 0 and stay in MEASURE. The edge restarts measurement.
- State LOCKED, on pps_pulse:
  - period ← P and period_valid pulses.
  - If P is good: stay in LOCKED.
  - If P is bad: locked ← 0, loss pulses for one cycle, good_cnt ← 0, go to MEASURE.
- Timeout (MEASURE or LOCKED): elapsed reaches CLK_FREQ+TOLERANCE+1 with no pps_pulse that cycle. Then go to SEARCH, good_cnt ← 0, locked ← 0. loss pulses only if locked was 1.
- Edge vs timeout in the same cycle: a pps_pulse in that cycle is treated as a bad-period edge (MEASURE path). No timeout fires.
- Timeout repeats: none while in SEARCH.
- IRQ stretch: a stretch counter loads IRQ_STRETCH on pps_pulse and decrements to 0. pps_irq = (counter != 0). A new pulse during stretch reloads the counter.
- period holds its last value across loss and SEARCH. It is cleared only by reset.
- Reset mid-period: everything returns to reset values immediately; the next edge is treated as the first edge.

Optional Feature:
- Macro: PPS_MONITOR_LOSS_IRQ_EN.
- Defined: pps_irq also loads the stretch counter on every loss strobe, so software is interrupted on lock loss.
- Undefined: pps_irq is driven only by PPS edges; loss is visible only as a port.

Decomposition:
- Shared package pps_monitor_pkg holds:
  - the state enum (SEARCH=0, MEASURE=1, LOCKED=2);
  - the window-check function in_window(P, CLK_FREQ, TOLERANCE).
- One sub-module: pulse_stretch (load/decrement counter, parameterised length), reused for the power-button IRQs.
- The synchroniser uses the existing synchronizer primitive.

Test Plan (CLK_FREQ=100, TOLERANCE=2, LOCK_COUNT=3, IRQ_STRETCH=4):
- Single rising edge on pps_in after reset → pps_pulse high exactly 3 cycles later for 1 cycle; pps_irq high 4 cycles; state MEASURE; no period_valid.
- Edges every 100 cycles ×4 → period=100 with period_valid on edges 2, 3 and 4; locked=1 on the 4th edge.
- While locked, one edge at 97 cycles → period=97, locked=0, loss pulses 1 cycle, state MEASURE; 3 more good edges relock.
- While locked, stop pps_in → loss pulses and locked=0 exactly 103 cycles after the last pps_pulse; state SEARCH; period stays 100.
- Edges at 98 then 102 cycles → both good, good_cnt increments; an edge at 103 coinciding with the timeout cycle → bad period, no timeout, good_cnt=0.
- Assert bus_rst mid-period while locked → all outputs 0 immediately; after release, the first edge gives no period_valid.
- With PPS_MONITOR_LOSS_IRQ_EN defined, timeout from LOCKED → pps_irq high 4 cycles starting with loss.

Source files
------------

// File: rtl/pps_monitor_pkg.sv
// Shared types and helpers for the PPS monitor: FSM state encoding and the
// good-period window check.
package pps_monitor_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Written as p + tol >= freq so that freq < tol cannot underflow.
    function automatic logic in_window(
        input longint unsigned p,
        input longint unsigned clk_freq,
        input longint unsigned tolerance
    );
        return ((p + tolerance) >= clk_freq) && (p <= (clk_freq + tolerance));
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: load reloads a down-counter to LEN and the
// output stays high while the counter is non-zero.
module pulse_stretch #(
    parameter int unsigned LEN = 32'd8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active
);

    localparam int unsigned W = $clog2(LEN + 32'd1);

    logic [W-1:0] cnt_d, cnt_q;
    logic         active_d, active_q;

    // Reload on load, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = '0;
        end
        active_d = (cnt_d != '0);
    end

    // Counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/pps_monitor.sv
// GPS PPS conditioner: synchroniser, edge strobe, stretched IRQ, period
// measurement and lock/loss FSM. Define PPS_MONITOR_LOSS_IRQ_EN to also
// raise pps_irq on every loss strobe.
module pps_monitor
    import pps_monitor_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 32'd100000000,
    parameter int unsigned TOLERANCE   = 32'd1000,
    parameter int unsigned LOCK_COUNT  = 32'd3,
    parameter int unsigned IRQ_STRETCH = 32'd8,
    parameter int unsigned CNT_W       = 32'd32
) (
    input  logic             bus_clk,
    input  logic             bus_rst,
    input  logic             pps_in,
    output logic             pps_out,
    output logic             pps_pulse,
    output logic             pps_irq,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             loss
);

    localparam int unsigned     GCNT_W      = $clog2(LOCK_COUNT + 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(CLK_FREQ + TOLERANCE);

    logic              s0_d, s0_q, s1_d, s1_q, d_d, d_q;
    logic              pulse_d, pulse_q;
    logic              pulse_s, good_s, timeout_s, stretch_load_s;
    logic [CNT_W-1:0]  cnt_d, cnt_q, elapsed_s;
    logic [CNT_W-1:0]  period_d, period_q;
    logic [GCNT_W-1:0] good_cnt_d, good_cnt_q, good_next_s;
    logic              period_valid_d, period_valid_q;
    logic              locked_d, locked_q, loss_d, loss_q;
    state_e            state_d, state_q;

    // The FSM acts on the same edge that registers pps_pulse, so period,
    // locked and loss change together with the visible strobe.
    always_comb begin
        s0_d        = pps_in;
        s1_d        = s0_q;
        d_d         = s1_q;
        pulse_s     = s1_q & ~d_q;
        pulse_d     = pulse_s;
        elapsed_s   = cnt_q + CNT_W'(1);
        good_s      = in_window(64'(elapsed_s), 64'(CLK_FREQ), 64'(TOLERANCE));
        timeout_s   = (cnt_q == TIMEOUT_CNT);
        good_next_s = good_cnt_q + GCNT_W'(1);
        if (pulse_s) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lock/loss next-state logic.
    always_comb begin
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        locked_d       = locked_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        loss_d         = 1'b0;
        case (state_q)
            SEARCH: begin
                if (pulse_s) begin
                    state_d    = MEASURE;
                    good_cnt_d = '0;
                end else begin
                    state_d = SEARCH;
                end
            end
            MEASURE, LOCKED: begin
                if (pulse_s) begin
                    period_d       = elapsed_s;
                    period_valid_d = 1'b1;
                    if (!good_s) begin
                        state_d    = MEASURE;
                        good_cnt_d = '0;
                        locked_d   = 1'b0;
                        loss_d     = locked_q;
                    end else if (state_q == LOCKED) begin
                        state_d = LOCKED;
                    end else if (good_next_s == GCNT_W'(LOCK_COUNT)) begin
                        state_d    = LOCKED;
                        good_cnt_d = good_next_s;
                        locked_d   = 1'b1;
                    end else begin
                        good_cnt_d = good_next_s;
                    end
                end else if (timeout_s) begin
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                    locked_d   = 1'b0;
                    loss_d     = locked_q;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = '0;
                locked_d   = 1'b0;
            end
        endcase
    end

    // All monitor state.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            s0_q           <= 1'b0;
            s1_q           <= 1'b0;
            d_q            <= 1'b0;
            pulse_q        <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            good_cnt_q     <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            loss_q         <= 1'b0;
            state_q        <= SEARCH;
        end else begin
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            d_q            <= d_d;
            pulse_q        <= pulse_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            good_cnt_q     <= good_cnt_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            loss_q         <= loss_d;
            state_q        <= state_d;
        end
    end

`ifdef PPS_MONITOR_LOSS_IRQ_EN
    assign stretch_load_s = pulse_s | loss_d;
`else
    assign stretch_load_s = pulse_s;
`endif

    pulse_stretch #(
        .LEN (IRQ_STRETCH)
    ) u_irq_stretch (
        .clk    (bus_clk),
        .rst    (bus_rst),
        .load   (stretch_load_s),
        .active (pps_irq)
    );

    assign pps_out      = d_q;
    assign pps_pulse    = pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign loss         = loss_q;

endmodule

// File: tb/tb_pps_monitor.sv
// Self-checking bench for pps_monitor: directed scenarios plus randomized PPS
// spacing, checked against an edge-event reference model.
module tb_pps_monitor;

    localparam int CF = 100;
    localparam int TOL = 2;
    localparam int LC = 3;
    localparam int IS = 4;
    localparam int CW = 16;
    localparam int TO = CF + TOL + 1;

    logic          bus_clk = 1'b0;
    logic          bus_rst;
    logic          pps_in;
    logic          pps_out, pps_pulse, pps_irq, period_valid, locked, loss;
    logic [CW-1:0] period;

    pps_monitor #(
        .CLK_FREQ(CF), .TOLERANCE(TOL), .LOCK_COUNT(LC), .IRQ_STRETCH(IS), .CNT_W(CW)
    ) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst), .pps_in(pps_in),
        .pps_out(pps_out), .pps_pulse(pps_pulse), .pps_irq(pps_irq),
        .period(period), .period_valid(period_valid), .locked(locked), .loss(loss)
    );

    always #5 bus_clk = ~bus_clk;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: input history, pulse times and lock bookkeeping.
    int            cyc, last_pulse, irq_until, m_state, m_good;
    int            since_rise, hold_w;
    logic [3:0]    hist;
    logic          e_out, e_pulse, e_irq, e_pv, e_locked, e_loss;
    logic [CW-1:0] e_period;
    int            mm_cnt;
    string         mm_msg;
    int            pv_seen, loss_seen, irq_seen;

    task automatic model_reset();
        cyc = 0; last_pulse = 0; irq_until = -1; m_state = 0; m_good = 0;
        hist = 4'b0; e_out = 0; e_pulse = 0; e_irq = 0; e_pv = 0;
        e_locked = 0; e_loss = 0; e_period = '0;
        since_rise = 1000; hold_w = 1;
    endtask

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic tick();
        int p;
        @(posedge bus_clk);
        cyc++;
        hist    = {hist[2:0], pps_in};
        e_out   = hist[2];
        e_pulse = hist[2] & ~hist[3];
        e_pv    = 0;
        e_loss  = 0;
        if (e_pulse) begin
            if (m_state != 0) begin
                p        = cyc - last_pulse;
                e_period = CW'(p);
                e_pv     = 1;
                if (p >= CF - TOL && p <= CF + TOL) begin
                    if (m_state == 1) begin
                        m_good++;
                        if (m_good == LC) begin
                            m_state  = 2;
                            e_locked = 1;
                        end
                    end
                end else begin
                    m_good   = 0;
                    e_loss   = e_locked;
                    e_locked = 0;
                    m_state  = 1;
                end
            end else begin
                m_state = 1;
            end
            last_pulse = cyc;
            irq_until  = cyc + IS - 1;
        end else if (m_state != 0 && cyc - last_pulse == TO) begin
            e_loss   = e_locked;
            e_locked = 0;
            m_state  = 0;
            m_good   = 0;
`ifdef PPS_MONITOR_LOSS_IRQ_EN
            if (e_loss) irq_until = cyc + IS - 1;
`endif
        end
        e_irq = (cyc <= irq_until);
        @(negedge bus_clk);
        if ({pps_out, pps_pulse, pps_irq, period_valid, locked, loss} !==
                {e_out, e_pulse, e_irq, e_pv, e_locked, e_loss} || period !== e_period) begin
            mm_cnt++;
            if (mm_msg == "")
                mm_msg = $sformatf("cycle %0d out/pulse/irq/pv/lock/loss=%b period=%0d, expected %b period=%0d",
                    cyc, {pps_out, pps_pulse, pps_irq, period_valid, locked, loss}, period,
                    {e_out, e_pulse, e_irq, e_pv, e_locked, e_loss}, e_period);
        end
        pv_seen   += int'(period_valid);
        loss_seen += int'(loss);
        irq_seen  += int'(pps_irq);
        since_rise++;
        if (since_rise >= hold_w) pps_in = 1'b0;
    endtask

    // Raise pps_in exactly p clocks after the previous rise, high for w clocks.
    task automatic rise_at(input int p, input int w);
        while (since_rise < p) tick();
        pps_in     = 1'b1;
        since_rise = 0;
        hold_w     = w;
    endtask

    task automatic test_reset();
        bus_rst = 1'b1;
        pps_in  = 1'b0;
        model_reset();
        repeat (2) @(negedge bus_clk);
        n_tests++;
        if ({pps_out, pps_pulse, pps_irq, period_valid, locked, loss} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                {pps_out, pps_pulse, pps_irq, period_valid, locked, loss});
        end
        n_tests++;
        if (period !== '0) begin
            n_fail++;
            $display("FAIL reset_period: got %0d expected 0", period);
        end
        bus_rst = 1'b0;
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_first_edge();
        logic p2, p3, pv3;
        irq_seen = 0; pv_seen = 0;
        rise_at(1, 5);
        tick(); tick(); p2 = pps_pulse;
        tick(); p3 = pps_pulse; pv3 = period_valid;
        repeat (10) tick();
        n_tests++;
        if ({p2, p3} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_edge_latency: pulse at cycles 2/3 got %b expected 01", {p2, p3});
        end
        n_tests++;
        if (irq_seen !== IS) begin
            n_fail++;
            $display("FAIL first_edge_irq_len: got %0d cycles expected %0d", irq_seen, IS);
        end
        n_tests++;
        if ({pv3, pv_seen != 0, locked} !== 3'b000) begin
            n_fail++;
            $display("FAIL first_edge_no_period: pv/any_pv/locked got %b expected 000", {pv3, pv_seen != 0, locked});
        end
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_first_edge: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_lock();
        logic [2:0] lk;
        pv_seen = 0;
        for (int k = 0; k < 3; k++) begin
            rise_at(CF, $urandom_range(1, 10));
            repeat (3) tick();
            lk[k] = locked & pps_pulse & (period == CW'(CF));
        end
        n_tests++;
        if (lk !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_on_fourth_edge: lock-at-pulse per edge got %b expected 100", lk);
        end
        n_tests++;
        if (pv_seen !== 3) begin
            n_fail++;
            $display("FAIL lock_period_valid_count: got %0d expected 3", pv_seen);
        end
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_lock: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_bad_period();
        logic [CW-1:0] per;
        logic          lk, ls, ls_next, lk2, lk3;
        rise_at(97, 5);
        repeat (3) tick();
        per = period; lk = locked; ls = loss;
        tick(); ls_next = loss;
        rise_at(CF, 3); repeat (3) tick();
        rise_at(CF, 3); repeat (3) tick(); lk2 = locked;
        rise_at(CF, 3); repeat (3) tick(); lk3 = locked;
        n_tests++;
        if (per !== CW'(97) || lk !== 1'b0 || {ls, ls_next} !== 2'b10) begin
            n_fail++;
            $display("FAIL bad_period_loss: period=%0d locked=%b loss=%b%b expected 97 0 10", per, lk, ls, ls_next);
        end
        n_tests++;
        if ({lk2, lk3} !== 2'b01) begin
            n_fail++;
            $display("FAIL relock: locked after 2nd/3rd good got %b expected 01", {lk2, lk3});
        end
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_bad_period: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_timeout();
        int loss_at;
        int irq_from_loss;
        loss_at = -1; loss_seen = 0; irq_from_loss = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (loss && loss_at < 0) loss_at = i;
            if (i >= TO && i < TO + 10) irq_from_loss += int'(pps_irq);
        end
        n_tests++;
        if (loss_at !== TO || loss_seen !== 1) begin
            n_fail++;
            $display("FAIL timeout_loss: first at %0d count %0d, expected at %0d count 1", loss_at, loss_seen, TO);
        end
        n_tests++;
        if (locked !== 1'b0 || period !== CW'(CF)) begin
            n_fail++;
            $display("FAIL timeout_hold: locked=%b period=%0d expected 0 %0d", locked, period, CF);
        end
        n_tests++;
`ifdef PPS_MONITOR_LOSS_IRQ_EN
        if (irq_from_loss !== IS) begin
            n_fail++;
            $display("FAIL timeout_loss_irq: got %0d irq cycles expected %0d", irq_from_loss, IS);
        end
`else
        if (irq_from_loss !== 0) begin
            n_fail++;
            $display("FAIL timeout_loss_irq: got %0d irq cycles expected 0", irq_from_loss);
        end
`endif
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_timeout: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_window_edges();
        logic [CW-1:0] p98, p102, p103;
        logic          pv103, ls103, lk_a, lk_b;
        rise_at(1, 4); repeat (3) tick();
        rise_at(CF - TOL, 4); repeat (3) tick(); p98 = period;
        rise_at(CF + TOL, 4); repeat (3) tick(); p102 = period;
        rise_at(CF + TOL + 1, 4); repeat (3) tick();
        p103 = period; pv103 = period_valid; ls103 = loss;
        rise_at(CF, 4); repeat (3) tick();
        rise_at(CF, 4); repeat (3) tick(); lk_a = locked;
        rise_at(CF, 4); repeat (3) tick(); lk_b = locked;
        n_tests++;
        if (p98 !== CW'(98) || p102 !== CW'(102)) begin
            n_fail++;
            $display("FAIL window_bounds: periods %0d %0d expected 98 102", p98, p102);
        end
        n_tests++;
        if (p103 !== CW'(103) || {pv103, ls103} !== 2'b10) begin
            n_fail++;
            $display("FAIL edge_on_timeout: period=%0d pv/loss=%b expected 103 10", p103, {pv103, ls103});
        end
        n_tests++;
        if ({lk_a, lk_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL good_cnt_cleared: locked after 2nd/3rd good got %b expected 01", {lk_a, lk_b});
        end
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_window: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_reset_mid();
        logic [5:0]    flags;
        logic [CW-1:0] per;
        logic          pv3, pl3;
        rise_at(CF, 5);
        repeat (40) tick();
        #2 bus_rst = 1'b1;
        #1 flags = {pps_out, pps_pulse, pps_irq, period_valid, locked, loss};
        per = period;
        repeat (2) @(negedge bus_clk);
        bus_rst = 1'b0;
        model_reset();
        mm_cnt = 0; mm_msg = "";
        rise_at(1, 5);
        repeat (3) tick();
        pl3 = pps_pulse; pv3 = period_valid;
        repeat (20) tick();
        n_tests++;
        if (flags !== 6'b0 || per !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: flags=%b period=%0d expected 000000 0", flags, per);
        end
        n_tests++;
        if ({pl3, pv3} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_edge: pulse/pv got %b expected 10", {pl3, pv3});
        end
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_reset_mid: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_back_to_back();
        rise_at(150, 1);
        irq_seen = 0;
        rise_at(3, 1);
        repeat (15) tick();
        n_tests++;
        if (irq_seen !== 3 + IS) begin
            n_fail++;
            $display("FAIL irq_reload: got %0d irq cycles expected %0d", irq_seen, 3 + IS);
        end
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_back_to_back: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    task automatic test_random();
        int p, sel;
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70) p = $urandom_range(CF - 4, CF + 4);
            else if (sel < 85) p = $urandom_range(2, 8);
            else p = $urandom_range(110, 150);
            rise_at(p, (p <= 8) ? 1 : $urandom_range(1, 5));
        end
        repeat (200) tick();
        n_tests++;
        if (mm_cnt !== 0) begin
            n_fail++;
            $display("FAIL model_random: %0d bad cycles, first: %s", mm_cnt, mm_msg);
        end
        mm_cnt = 0; mm_msg = "";
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_lock();
        test_bad_period();
        test_timeout();
        test_window_edges();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
